// File: rtl/spi_btn_reader.sv
// spi_btn_reader: SPI master that reads the button shift register over CSn/SCLK/MISO
// and delivers the captured word in natural bit order.
`default_nettype none

module spi_btn_reader #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic             clk_25mhz,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             spi_csn,
  output logic             spi_clk,
  input  logic             spi_miso
);

  localparam int PMAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int PW   = $clog2(PMAX);
  localparam int BW   = $clog2(WIDTH);

  localparam logic [PW-1:0] LAST_DIV  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LAST_IDLE = PW'(CS_IDLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    phase_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;
  logic             valid_q;
  logic             csn_q;
  logic             sclk_q;
  logic             sync1_q;
  logic             sync2_q;

  logic [BW-1:0]    slot_d;
  logic [WIDTH-1:0] word_d;

  // The responder shifts out b0 first, then b7..b1, so sample k>1 lands in WIDTH+1-k.
  always_comb begin
    slot_d         = (bit_q == '0) ? '0 : BW'(WIDTH) - bit_q;
    word_d         = shift_q;
    word_d[slot_d] = sync2_q;
  end

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= spi_miso;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          csn_q  <= 1'b1;
          sclk_q <= 1'b0;
          if (start) begin
            state_q <= LOW;
            csn_q   <= 1'b0;
            busy_q  <= 1'b1;
            bit_q   <= '0;
            phase_q <= '0;
          end
        end
        LOW: begin
          if (phase_q == LAST_DIV) begin
            shift_q <= word_d;
            sclk_q  <= 1'b1;
            phase_q <= '0;
            state_q <= HIGH;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        HIGH: begin
          if (phase_q == LAST_DIV) begin
            sclk_q  <= 1'b0;
            phase_q <= '0;
            if (bit_q != LAST_BIT) begin
              bit_q   <= bit_q + BW'(1);
              state_q <= LOW;
            end else begin
              csn_q   <= 1'b1;
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        HOLD: begin
          // CSn stays high long enough for the responder to reload its register.
          if (phase_q == LAST_IDLE) begin
            phase_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign spi_csn    = csn_q;
  assign spi_clk    = sclk_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_btn_reader.sv
// tb_spi_btn_reader: drives spi_btn_reader against a behavioural button-register responder.
`default_nettype none

module tb_spi_btn_reader;

  localparam int WIDTH    = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_IDLE  = 4;
  localparam int LAT      = 2 * CLK_DIV * WIDTH + 1;
  localparam int BUSY_LEN = 2 * CLK_DIV * WIDTH + CS_IDLE;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             start = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             spi_csn;
  logic             spi_clk;
  logic             spi_miso;
  logic [6:0]       btn = 7'd0;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  spi_btn_reader #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk_25mhz (clk),
    .rstn      (rstn),
    .start     (start),
    .busy      (busy),
    .data      (data),
    .data_valid(data_valid),
    .spi_csn   (spi_csn),
    .spi_clk   (spi_clk),
    .spi_miso  (spi_miso)
  );

  // Responder: loaded word {0,btn} rotated left once per SCLK rise; MISO is bit 0.
  int         rot = 0;
  logic [7:0] ld;
  logic [2:0] idx;
  always @(posedge spi_clk or posedge spi_csn) begin
    if (spi_csn) rot <= 0;
    else         rot <= rot + 1;
  end
  always_comb begin
    ld  = {1'b0, btn};
    idx = 3'((WIDTH - (rot % WIDTH)) % WIDTH);
  end
  assign spi_miso = ld[idx];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sclk_edges = 0;
  always @(posedge spi_clk) sclk_edges <= sclk_edges + 1;

  // Scoreboard: each accepted start expects {0,btn}; each data_valid consumes one.
  logic [7:0] expq[$];
  int   dv_count = 0, dv_cyc = -1, dv_bad = 0;
  int   busy_rise_cyc = -1, busy_fall_cyc = -1;
  int   glitches = 0, min_gap = 100000, gap_run = 0;
  logic busy_prev = 1'b0, csn_prev = 1'b1, sclk_prev = 1'b0, seen_low = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      expq.delete();
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        expq.push_back({1'b0, btn});
        busy_rise_cyc = cyc;
      end
      if (!busy && busy_prev) busy_fall_cyc = cyc;
      busy_prev = busy;
      if (data_valid) begin
        dv_count++;
        dv_cyc = cyc;
        if (expq.size() == 0) dv_bad++;
        else begin
          if (data !== expq[0]) dv_bad++;
          void'(expq.pop_front());
        end
      end
    end
    if (spi_csn) gap_run++;
    else begin
      if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
      seen_low = 1'b1;
      gap_run  = 0;
    end
    if (spi_clk && !sclk_prev && (spi_csn !== csn_prev)) glitches++;
    sclk_prev = spi_clk;
    csn_prev  = spi_csn;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic do_transfer(input logic [6:0] b, input string tag);
    int e0, d0, t0;
    btn = b;
    repeat (4) @(negedge clk);
    e0 = sclk_edges;
    d0 = dv_count;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_idle(tag);
    @(negedge clk);
    check({tag, "_data"},  32'(data), {24'd0, 1'b0, b});
    check({tag, "_edges"}, 32'(sclk_edges - e0), WIDTH);
    check({tag, "_dvcnt"}, 32'(dv_count - d0), 32'd1);
    check({tag, "_lat"},   32'(dv_cyc - t0), LAT);
    check({tag, "_brise"}, 32'(busy_rise_cyc - t0), 32'd1);
    check({tag, "_bfall"}, 32'(busy_fall_cyc - t0), BUSY_LEN + 1);
  endtask

  initial begin
    #(2ms);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, d0, e0, n;
    logic [6:0] b;

    #5 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("rst_csn",  32'(spi_csn), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'd0);

    repeat (20) @(negedge clk);
    check("idle_csn",  32'(spi_csn), 32'd1);
    check("idle_sclk", 32'(spi_clk), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_data", 32'(data), 32'd0);
    check("idle_dv",   32'(dv_count), 32'd0);

    do_transfer(7'b1010101, "t55");
    do_transfer(7'b0000001, "t01");
    do_transfer(7'b1000000, "t40");
    for (int i = 0; i < 4; i++) do_transfer(7'($urandom), "rand");

    // Starts during a transfer and in the last busy cycle must be dropped.
    b = 7'($urandom);
    btn = b;
    repeat (4) @(negedge clk);
    d0 = dv_count;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    for (int c = 1; c <= 75; c++) begin
      start = (c == 10 || c == 30 || c == BUSY_LEN);
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_dvcnt", 32'(dv_count - d0), 32'd1);
    check("ign_busy",  32'(busy), 32'd0);
    check("ign_bfall", 32'(busy_fall_cyc - t0), BUSY_LEN + 1);
    check("ign_brise", 32'(busy_rise_cyc - t0), 32'd1);
    check("ign_data",  32'(data), {24'd0, 1'b0, b});

    // Start held high: one transfer every BUSY_LEN+1 cycles.
    btn = 7'h7F;
    repeat (4) @(negedge clk);
    d0 = dv_count;
    start = 1'b1;
    repeat (300) @(negedge clk);
    start = 1'b0;
    wait_idle("b2b");
    @(negedge clk);
    check("b2b_dvcnt", 32'(dv_count - d0), 32'd5);
    check("b2b_data",  32'(data), 32'h7F);
    check("b2b_gap",   32'(min_gap >= CS_IDLE), 32'd1);

    // Asynchronous reset after the 4th SCLK rise.
    b = 7'($urandom);
    btn = b;
    repeat (4) @(negedge clk);
    e0 = sclk_edges;
    d0 = dv_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((sclk_edges - e0) < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_edges", 32'(sclk_edges - e0), 32'd4);
    rstn = 1'b0;
    #1;
    check("mid_csn",  32'(spi_csn), 32'd1);
    check("mid_sclk", 32'(spi_clk), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_dv",   32'(data_valid), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_nodv", 32'(dv_count - d0), 32'd0);
    do_transfer(7'($urandom), "post");

    check("glitches", 32'(glitches), 32'd0);
    check("sb_bad",   32'(dv_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
